free_list: RTL and testbench
============================

# free_list

- Physical-register free list for the 2-wide R10000-style core; the other end of the ROB's retire/dispatch register traffic.
- Supplies new destination tags (T_idx) to the ROB/Map Table at dispatch.
- Reclaims Told_idx tags from the ROB at retire.
- On branch rollback, restores its head from a per-ROB-entry checkpoint so tags allocated by squashed instructions become free again.

## Interface
Parameters:
- NUM_PR, 64, physical registers; PRW = $clog2(NUM_PR)
- NUM_ARCH, 32, architectural registers; initial free tags are NUM_ARCH..NUM_PR-1
- NUM_ROB, 32, ROB entries; RW = $clog2(NUM_ROB)
- ZERO_PR, 31, physical tag of the zero register; never allocated, never freed

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- en  in  1  global stall; 0 freezes all state
- dispatch_en  in  1  dispatch the 2-instruction bundle this cycle
- dest_zero  in  [1:0]  lane i has no destination (dest is zero reg)
- ROB_idx  in  [1:0][RW-1:0]  ROB slots of the dispatched lanes
- retire_en  in  [1:0]  ROB retiring lane i (lane1 implies lane0)
- Told_idx  in  [1:0][PRW-1:0]  old tags released by retiring lanes
- rollback_en  in  1  mispredict recovery
- ROB_rollback_idx  in  [RW-1:0]  ROB slot of the mispredicted branch
- T_idx  out  [1:0][PRW-1:0]  tags for the current bundle (combinational)
- FL_valid  out  1  enough free tags for the bundle, and no rollback this cycle
- free_count  out  [PRW:0]  current number of free tags

## Operation
- Storage: circular buffer `fl[NUM_PR]` of PRW-bit tags.
- Pointers: head and tail, each PRW+1 bits (wrap bit). free_count = tail - head.
- Checkpoints: `ckpt[NUM_ROB]` of PRW+1-bit head values.
- Allocation:
  - need = number of lanes with dest_zero=0 (0..2).
  - Lane 0: T_idx[0] = dest_zero[0] ? ZERO_PR : fl[head].
  - Lane 1: T_idx[1] = dest_zero[1] ? ZERO_PR : fl[head + (dest_zero[0]?0:1)].
  - FL_valid = !rollback_en && free_count >= need.
- Pop: dispatch_en && !rollback_en → head += need.
- Checkpoint write on each dispatch:
  - ckpt[ROB_idx[0]] = head + (dest_zero[0]?0:1)
  - ckpt[ROB_idx[1]] = head + need
- Retire:
  - Each lane with retire_en[i] && Told_idx[i] != ZERO_PR is written at fl[tail], lane 0 first.
  - tail += pushes (0..2). Retire applies regardless of rollback_en.
- Rollback: rollback_en → head = ckpt[ROB_rollback_idx]. Dispatch that cycle is ignored (no pop, no checkpoint write).
- dispatch_en asserted while free_count < need: this is a protocol error. The block must not pop; head is held.
- Overflow cannot occur: free_count ≤ NUM_PR - NUM_ARCH is invariant. A push beyond that is a protocol error.
- Reset state:
  - fl[i] = NUM_ARCH + i for i < NUM_PR - NUM_ARCH; all other entries 0.
  - head = 0, tail = NUM_PR - NUM_ARCH (free_count = 32).
  - ckpt all 0.
- Reset outputs: T_idx = {33, 32}, FL_valid = 1 (when dest_zero=0 and rollback_en=0).

## Timing
- T_idx, FL_valid and free_count are combinational from registered state and same-cycle inputs; zero-cycle lookahead.
- Pops, pushes, checkpoint writes and the rollback head restore take effect at the next posedge when en=1.
- A retired tag is reallocatable from the cycle after retire; there is no same-cycle bypass.
- Simultaneous dispatch + retire: free_count for FL_valid uses pre-retire state; both updates commit together.
- Simultaneous rollback + retire: head restored, tail advanced, same edge.
- Wrap-around: indices are pointer[PRW-1:0]; the wrap bit distinguishes full from empty.
- Async reset asserted mid-operation: state returns to the reset values immediately, independent of clock or en.

## Test plan
- Reset, dispatch_en=1, dest_zero=00 for 3 cycles → T_idx {33,32}, {35,34}, {37,36}; free_count 32→26.
- 16 full dispatches drain to free_count=0 → FL_valid=0 for need=2. Retire Told {5,4} → next cycle T_idx={5,4}, FL_valid=1.
- dest_zero=01 → T_idx[0]=31, T_idx[1]=fl[head]; head+1. Retire Told=31 → no push, free_count unchanged.
- Branch dispatched at ROB 3 (head→2), two further bundles, rollback_en with idx 3 → head=2, free_count restored; FL_valid=0 in the rollback cycle.
- Rollback and retire of 2 tags in the same cycle → head restored and tail +2; free_count = checkpoint count + 2.
- Push/pop across index 63→0 → tags are continuous, free_count correct. Assert async reset mid-cycle → outputs show reset values before the next edge.

Source files
------------

// File: rtl/free_list.sv
// Physical-register free list: hands out destination tags at dispatch, reclaims old tags at retire.
// Latency: T_idx/FL_valid/free_count are combinational; pops, pushes and restores commit at the next edge with en=1.
// Backpressure: FL_valid drops when the bundle needs more tags than are free or a rollback is in progress; no pop then.
//
// Ports:
//   clock, reset        clock and asynchronous active-high reset
//   en                  global stall, 0 freezes every register
//   dispatch_en         2-wide bundle dispatching; dest_zero[i] marks lanes without a destination
//   ROB_idx             ROB slots of the two lanes; their checkpoints are written on an accepted dispatch
//   retire_en/Told_idx  old tags handed back by retiring lanes (lane 0 pushed first)
//   rollback_en         restore head from the checkpoint at ROB_rollback_idx
//   T_idx               tags for this cycle's bundle; FL_valid says they may be used
//   free_count          tail - head
module free_list #(
  parameter  int NUM_PR   = 64,
  parameter  int NUM_ARCH = 32,
  parameter  int NUM_ROB  = 32,
  parameter  int ZERO_PR  = 31,
  localparam int PRW      = $clog2(NUM_PR),
  localparam int RW       = $clog2(NUM_ROB)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     dispatch_en,
  input  logic [1:0]               dest_zero,
  input  logic [1:0][RW-1:0]       ROB_idx,
  input  logic [1:0]               retire_en,
  input  logic [1:0][PRW-1:0]      Told_idx,
  input  logic                     rollback_en,
  input  logic [RW-1:0]            ROB_rollback_idx,
  output logic [1:0][PRW-1:0]      T_idx,
  output logic                     FL_valid,
  output logic [PRW:0]             free_count
);

  localparam logic [PRW-1:0] ZERO_TAG = PRW'(ZERO_PR);

  // Circular tag storage and pointers; the extra pointer bit separates full from empty.
  logic [PRW-1:0] fl_q   [NUM_PR];
  logic [PRW-1:0] fl_d   [NUM_PR];
  logic [PRW:0]   head_q, head_d;
  logic [PRW:0]   tail_q, tail_d;
  // Head value to return to when the instruction in each ROB slot is squashed.
  logic [PRW:0]   ckpt_q [NUM_ROB];
  logic [PRW:0]   ckpt_d [NUM_ROB];

  logic [1:0]     need;
  logic [PRW:0]   head_lane1;
  logic           enough;
  logic           pop;
  logic           push0;
  logic           push1;
  logic [PRW-1:0] tail_lane1_idx;

  always_comb begin
    need       = {1'b0, ~dest_zero[0]} + {1'b0, ~dest_zero[1]};
    // Lane 1 reads one slot further only when lane 0 consumed a tag.
    head_lane1 = head_q + {{PRW{1'b0}}, ~dest_zero[0]};
    free_count = tail_q - head_q;
    enough     = free_count >= {{(PRW-1){1'b0}}, need};

    T_idx[0]   = dest_zero[0] ? ZERO_TAG : fl_q[head_q[PRW-1:0]];
    T_idx[1]   = dest_zero[1] ? ZERO_TAG : fl_q[head_lane1[PRW-1:0]];
    FL_valid   = !rollback_en && enough;

    // A dispatch without enough free tags is dropped rather than underflowing head.
    pop        = dispatch_en && !rollback_en && enough;
    push0      = retire_en[0] && (Told_idx[0] != ZERO_TAG);
    push1      = retire_en[1] && (Told_idx[1] != ZERO_TAG);
    tail_lane1_idx = tail_q[PRW-1:0] + {{(PRW-1){1'b0}}, push0};

    fl_d   = fl_q;
    ckpt_d = ckpt_q;
    head_d = head_q;
    tail_d = tail_q + {{PRW{1'b0}}, push0} + {{PRW{1'b0}}, push1};

    if (push0) fl_d[tail_q[PRW-1:0]] = Told_idx[0];
    if (push1) fl_d[tail_lane1_idx]  = Told_idx[1];

    if (rollback_en) begin
      head_d = ckpt_q[ROB_rollback_idx];
    end else if (pop) begin
      // Each lane's checkpoint is the head just after its own allocation,
      // so a rollback to that slot keeps the lane's tag and frees everything younger.
      ckpt_d[ROB_idx[0]] = head_lane1;
      ckpt_d[ROB_idx[1]] = head_q + {{(PRW-1){1'b0}}, need};
      head_d             = head_q + {{(PRW-1){1'b0}}, need};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PR; i++) begin
        fl_q[i] <= (i < NUM_PR - NUM_ARCH) ? PRW'(NUM_ARCH + i) : '0;
      end
      for (int r = 0; r < NUM_ROB; r++) begin
        ckpt_q[r] <= '0;
      end
      head_q <= '0;
      tail_q <= (PRW+1)'(NUM_PR - NUM_ARCH);
    end else if (en) begin
      fl_q   <= fl_d;
      ckpt_q <= ckpt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;

  localparam int PRW = 6;
  localparam int RW  = 5;
  localparam int SEQ_MAX = 8192;

  logic                clock = 1'b0;
  logic                reset;
  logic                en;
  logic                dispatch_en;
  logic [1:0]          dest_zero;
  logic [1:0][RW-1:0]  ROB_idx;
  logic [1:0]          retire_en;
  logic [1:0][PRW-1:0] Told_idx;
  logic                rollback_en;
  logic [RW-1:0]       ROB_rollback_idx;
  logic [1:0][PRW-1:0] T_idx;
  logic                FL_valid;
  logic [PRW:0]        free_count;

  free_list dut (
    .clock            (clock),
    .reset            (reset),
    .en               (en),
    .dispatch_en      (dispatch_en),
    .dest_zero        (dest_zero),
    .ROB_idx          (ROB_idx),
    .retire_en        (retire_en),
    .Told_idx         (Told_idx),
    .rollback_en      (rollback_en),
    .ROB_rollback_idx (ROB_rollback_idx),
    .T_idx            (T_idx),
    .FL_valid         (FL_valid),
    .free_count       (free_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an unbounded log of every tag ever made free, with absolute head/tail
  // positions. Allocation reads the log at head, rollback moves head back to a
  // remembered absolute position; no circular indexing involved.
  int seq [SEQ_MAX];
  int mh, mt;
  int mck [32];

  function automatic int need_of(input logic [1:0] dz);
    return (dz[0] ? 0 : 1) + (dz[1] ? 0 : 1);
  endfunction

  always @(posedge clock or posedge reset) begin : model
    int fc, nd, nh;
    if (reset) begin
      for (int i = 0; i < 32; i++) seq[i] = 32 + i;
      for (int r = 0; r < 32; r++) mck[r] = 0;
      mh = 0;
      mt = 32;
    end else if (en) begin
      fc = mt - mh;
      nd = need_of(dest_zero);
      nh = mh;
      if (rollback_en) begin
        nh = mck[ROB_rollback_idx];
      end else if (dispatch_en && fc >= nd) begin
        mck[ROB_idx[0]] = mh + (dest_zero[0] ? 0 : 1);
        mck[ROB_idx[1]] = mh + nd;
        nh = mh + nd;
      end
      for (int l = 0; l < 2; l++) begin
        if (retire_en[l] && Told_idx[l] != 31 && mt < SEQ_MAX) begin
          seq[mt] = Told_idx[l];
          mt++;
        end
      end
      mh = nh;
    end
  end

  // Compare process: outputs are checked mid-cycle, away from the active edge.
  always @(negedge clock) begin : compare
    int fc, nd, p1;
    if (!reset) begin
      fc = mt - mh;
      nd = need_of(dest_zero);
      chk("free_count", free_count, fc);
      chk("FL_valid", FL_valid, (!rollback_en && fc >= nd) ? 1 : 0);
      if (dest_zero[0]) chk("T_idx0_zero", T_idx[0], 31);
      else if (mh < mt) chk("T_idx0", T_idx[0], seq[mh]);
      p1 = mh + (dest_zero[0] ? 0 : 1);
      if (dest_zero[1]) chk("T_idx1_zero", T_idx[1], 31);
      else if (p1 < mt) chk("T_idx1", T_idx[1], seq[p1]);
    end
  end

  task automatic idle();
    dispatch_en      = 1'b0;
    dest_zero        = 2'b00;
    ROB_idx          = '0;
    retire_en        = 2'b00;
    Told_idx         = '0;
    rollback_en      = 1'b0;
    ROB_rollback_idx = '0;
  endtask

  task automatic disp(input logic [1:0] dz, input int r0, input int r1);
    idle();
    dispatch_en = 1'b1;
    dest_zero   = dz;
    ROB_idx[0]  = RW'(r0);
    ROB_idx[1]  = RW'(r1);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin : stim
    int rob_ptr, cand, np, fc;
    bit cand_vld, rb;
    reset = 1'b1;
    en    = 1'b1;
    idle();
    #12;
    // Reset state, while reset is still asserted.
    chk("rst_T0", T_idx[0], 32);
    chk("rst_T1", T_idx[1], 33);
    chk("rst_FL_valid", FL_valid, 1);
    chk("rst_free_count", free_count, 32);
    #10 reset = 1'b0;
    step();

    // Three full bundles straight out of reset.
    for (int k = 0; k < 3; k++) begin
      disp(2'b00, 2 * k, 2 * k + 1);
      #1;
      chk("p1_T0", T_idx[0], 32 + 2 * k);
      chk("p1_T1", T_idx[1], 33 + 2 * k);
      chk("p1_fc", free_count, 32 - 2 * k);
      step();
    end
    chk("p1_fc_end", free_count, 26);

    // Drain to empty.
    for (int k = 3; k < 16; k++) begin
      disp(2'b00, (2 * k) % 32, (2 * k + 1) % 32);
      step();
    end
    disp(2'b00, 0, 1);
    #1;
    chk("empty_fc", free_count, 0);
    chk("empty_FL_valid", FL_valid, 0);
    step();
    chk("empty_hold_fc", free_count, 0);
    idle();
    retire_en   = 2'b11;
    Told_idx[0] = 6'd4;
    Told_idx[1] = 6'd5;
    step();
    idle();
    #1;
    chk("reclaim_T0", T_idx[0], 4);
    chk("reclaim_T1", T_idx[1], 5);
    chk("reclaim_FL_valid", FL_valid, 1);
    chk("reclaim_fc", free_count, 2);

    // Lane 0 without a destination: lane 1 takes the head tag.
    disp(2'b01, 6, 7);
    #1;
    chk("dz01_T0", T_idx[0], 31);
    chk("dz01_T1", T_idx[1], 4);
    step();
    idle();
    retire_en   = 2'b01;
    Told_idx[0] = 6'd31;
    step();
    idle();
    #1;
    chk("zero_retire_fc", free_count, 1);
    chk("zero_retire_T0", T_idx[0], 5);

    // Refill with tags 10..19.
    for (int k = 0; k < 5; k++) begin
      idle();
      retire_en   = 2'b11;
      Told_idx[0] = PRW'(10 + 2 * k);
      Told_idx[1] = PRW'(11 + 2 * k);
      step();
    end

    // Branch in ROB slot 3, two younger bundles, then rollback.
    disp(2'b00, 2, 3);  step();
    disp(2'b00, 4, 5);  step();
    disp(2'b00, 6, 7);  step();
    disp(2'b00, 8, 9);
    rollback_en      = 1'b1;
    ROB_rollback_idx = 5'd3;
    #1;
    chk("rb_FL_valid", FL_valid, 0);
    chk("rb_fc_before", free_count, 5);
    step();
    idle();
    #1;
    chk("rb_fc_after", free_count, 9);
    chk("rb_T0", T_idx[0], 11);
    chk("rb_T1", T_idx[1], 12);

    // Rollback and a two-tag retire on the same edge.
    disp(2'b00, 10, 11); step();
    disp(2'b00, 12, 13); step();
    idle();
    rollback_en      = 1'b1;
    ROB_rollback_idx = 5'd3;
    retire_en        = 2'b11;
    Told_idx[0]      = 6'd20;
    Told_idx[1]      = 6'd21;
    step();
    idle();
    #1;
    chk("rb_retire_fc", free_count, 11);
    chk("rb_retire_T0", T_idx[0], 11);

    // Steady dispatch + retire carries both pointers across index 63 -> 0.
    for (int k = 0; k < 40; k++) begin
      disp(2'b00, (2 * k) % 32, (2 * k + 1) % 32);
      retire_en   = 2'b11;
      Told_idx[0] = PRW'(32 + (k % 16) * 2);
      Told_idx[1] = PRW'(33 + (k % 16) * 2);
      step();
    end
    idle();
    #1;
    chk("wrap_fc", free_count, 11);

    // Random legal traffic including stalls and rollbacks.
    rob_ptr  = 0;
    cand     = 0;
    cand_vld = 1'b0;
    for (int k = 0; k < 400; k++) begin
      idle();
      fc          = mt - mh;
      en          = ($urandom_range(0, 9) != 0);
      dispatch_en = ($urandom_range(0, 2) != 0);
      dest_zero   = 2'($urandom_range(0, 3));
      ROB_idx[0]  = RW'(rob_ptr % 32);
      ROB_idx[1]  = RW'((rob_ptr + 1) % 32);
      np          = $urandom_range(0, 2);
      if (fc + np > 32) np = 32 - fc;
      retire_en   = (np == 2) ? 2'b11 : (np == 1) ? 2'b01 : 2'b00;
      Told_idx[0] = PRW'($urandom_range(0, 63));
      Told_idx[1] = PRW'($urandom_range(0, 63));
      rb = cand_vld && ($urandom_range(0, 7) == 0) && (mt + 2 - mck[cand] <= 32);
      if (rb) begin
        rollback_en      = 1'b1;
        ROB_rollback_idx = RW'(cand);
      end
      if (en) begin
        if (rb) begin
          cand_vld = 1'b0;
        end else if (dispatch_en && fc >= need_of(dest_zero)) begin
          if (!cand_vld) begin
            cand     = rob_ptr % 32;
            cand_vld = 1'b1;
          end
          rob_ptr += 2;
        end
      end
      step();
    end
    en = 1'b1;
    idle();

    // Asynchronous reset between edges.
    disp(2'b00, 0, 1);
    step();
    #2;
    reset = 1'b1;
    idle();
    #1;
    chk("async_rst_T0", T_idx[0], 32);
    chk("async_rst_T1", T_idx[1], 33);
    chk("async_rst_FL_valid", FL_valid, 1);
    chk("async_rst_fc", free_count, 32);
    #10 reset = 1'b0;
    step();
    disp(2'b00, 0, 1); step();
    disp(2'b10, 2, 3); step();
    idle();
    #1;
    chk("post_rst_fc", free_count, 29);
    chk("post_rst_T0", T_idx[0], 35);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
